// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// the ResultSrc value that marks a load in the execute stage.
package pipeline_pkg;

  typedef enum logic [1:0] {
    StRun        = 2'd0,
    StMissWait   = 2'd1,
    StMissResume = 2'd2
  } hazard_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the execute-stage destination and
// the decode-stage source registers.
module hazard_detect
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SRC_WIDTH      = 2
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic [SRC_WIDTH-1:0]      result_src_e,
  input  logic                      valid_e,
  output logic                      load_use
);

  logic is_load;
  logic rd_nonzero;
  logic src_match;

  always_comb begin
    is_load    = valid_e && (result_src_e == SRC_WIDTH'(RESULT_SRC_LOAD));
    rd_nonzero = (rd_e != '0);
    src_match  = (rd_e == rs1_d) || (rd_e == rs2_d);
    load_use   = is_load && rd_nonzero && src_match;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: data-cache miss FSM plus branch and load-use handling.
// Define HAZARD_PERF_CNT_EN to build the saturating fetch-stall cycle counter.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned SRC_WIDTH      = 2,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_e,
  input  logic [SRC_WIDTH-1:0]      result_src_e,
  input  logic                      valid_e,
  input  logic                      pc_src_e,
  input  logic                      dcache_miss_m,
  input  logic                      dcache_ready,
  output logic                      en_f,
  output logic                      en_d,
  output logic                      en_e,
  output logic                      en_m,
  output logic                      flush_d_n,
  output logic                      flush_e_n,
  output logic                      bubble_e,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  hazard_state_t state_q, state_d;
  logic          load_use;
  logic          apply_hazards;

  hazard_detect #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .SRC_WIDTH      (SRC_WIDTH)
  ) u_hazard_detect (
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .rd_e         (rd_e),
    .result_src_e (result_src_e),
    .valid_e      (valid_e),
    .load_use     (load_use)
  );

  always_comb begin
    state_d       = state_q;
    en_f          = 1'b1;
    en_d          = 1'b1;
    en_e          = 1'b1;
    en_m          = 1'b1;
    flush_d_n     = 1'b1;
    flush_e_n     = 1'b1;
    bubble_e      = 1'b0;
    apply_hazards = 1'b0;

    if (!rst_n) begin
      // Clear decode/execute while reset is held.
      flush_d_n = 1'b0;
      flush_e_n = 1'b0;
      state_d   = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (dcache_miss_m) begin
            {en_f, en_d, en_e, en_m} = 4'b0000;
            state_d                  = StMissWait;
          end else begin
            apply_hazards = 1'b1;
          end
        end
        StMissWait: begin
          {en_f, en_d, en_e, en_m} = 4'b0000;
          if (dcache_ready) begin
            state_d = StMissResume;
          end
        end
        StMissResume: begin
          apply_hazards = 1'b1;
          state_d       = StRun;
        end
        default: state_d = StRun;
      endcase

      // A taken branch discards the dependent instruction, so it wins over load-use.
      if (apply_hazards) begin
        if (pc_src_e) begin
          flush_d_n = 1'b0;
          flush_e_n = 1'b0;
        end else if (load_use) begin
          en_f     = 1'b0;
          en_d     = 1'b0;
          bubble_e = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!en_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized stimulus, all compared against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW    = 5;
  localparam int unsigned SW    = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  // Output vector order: {en_f, en_d, en_e, en_m, flush_d_n, flush_e_n, bubble_e}
  localparam logic [6:0] OUT_RESET = 7'b1111_00_0;
  localparam logic [6:0] OUT_STALL = 7'b0000_11_0;
  localparam logic [6:0] OUT_FLUSH = 7'b1111_00_0;
  localparam logic [6:0] OUT_LDUSE = 7'b0011_11_1;
  localparam logic [6:0] OUT_IDLE  = 7'b1111_11_0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs1_d, rs2_d, rd_e;
  logic [SW-1:0] result_src_e;
  logic          valid_e, pc_src_e, dcache_miss_m, dcache_ready;
  logic          en_f, en_d, en_e, en_m, flush_d_n, flush_e_n, bubble_e;
  logic [CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "waiting for refill" and "in the post-refill slot".
  bit waiting  = 1'b0;
  bit resuming = 1'b0;
  int exp_cnt  = 0;

  logic [6:0] last_out;
  logic [CNT_W-1:0] last_cnt;

  pipeline_hazard_ctrl #(
    .REG_ADDR_WIDTH (AW),
    .SRC_WIDTH      (SW),
    .CNT_WIDTH      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rs1_d         (rs1_d),
    .rs2_d         (rs2_d),
    .rd_e          (rd_e),
    .result_src_e  (result_src_e),
    .valid_e       (valid_e),
    .pc_src_e      (pc_src_e),
    .dcache_miss_m (dcache_miss_m),
    .dcache_ready  (dcache_ready),
    .en_f          (en_f),
    .en_d          (en_d),
    .en_e          (en_e),
    .en_m          (en_m),
    .flush_d_n     (flush_d_n),
    .flush_e_n     (flush_e_n),
    .bubble_e      (bubble_e),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] model_out();
    bit ld_use;
    ld_use = valid_e && (result_src_e == 2'b01) && (rd_e != 0) &&
             ((rd_e == rs1_d) || (rd_e == rs2_d));
    if (!rst_n)                      return OUT_RESET;
    if (waiting)                     return OUT_STALL;
    if (!resuming && dcache_miss_m)  return OUT_STALL;
    if (pc_src_e)                    return OUT_FLUSH;
    if (ld_use)                      return OUT_LDUSE;
    return OUT_IDLE;
  endfunction

  function automatic int model_cnt();
`ifdef HAZARD_PERF_CNT_EN
    return exp_cnt;
`else
    return 0;
`endif
  endfunction

  // Inputs must already be set; checks at negedge, model advances at posedge.
  task automatic step(input string tag);
    logic [6:0] exp_v;
    @(negedge clk);
    exp_v    = model_out();
    last_out = {en_f, en_d, en_e, en_m, flush_d_n, flush_e_n, bubble_e};
    last_cnt = stall_cycles;
    check_eq({tag, "_out"}, 32'(last_out), 32'(exp_v));
    check_eq({tag, "_cnt"}, 32'(last_cnt), 32'(model_cnt()));
    @(posedge clk);
    if (!rst_n) begin
      waiting  = 1'b0;
      resuming = 1'b0;
      exp_cnt  = 0;
    end else begin
      if (!exp_v[6] && exp_cnt < int'(CNT_MAX)) exp_cnt++;
      if (waiting) begin
        if (dcache_ready) begin
          waiting  = 1'b0;
          resuming = 1'b1;
        end
      end else if (resuming) begin
        resuming = 1'b0;
      end else if (dcache_miss_m) begin
        waiting = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; rs1_d = '0; rs2_d = '0; rd_e = '0; result_src_e = '0;
    valid_e = 1'b0; pc_src_e = 1'b0; dcache_miss_m = 1'b0; dcache_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step("rst");
    step("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    int zero_en;
    idle_inputs();
    #1;
    do_reset();
    check_eq("reset_outs", 32'(last_out), 32'(OUT_RESET));
    step("post_rst");
    check_eq("post_rst_outs", 32'(last_out), 32'(OUT_IDLE));
    check_eq("post_rst_cnt", 32'(last_cnt), 32'd0);

    // Load-use on rs1: one bubble, then the bubble clears the hazard.
    rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd9; result_src_e = 2'b01; valid_e = 1'b1;
    step("lduse");
    check_eq("lduse_outs", 32'(last_out), 32'(OUT_LDUSE));
    valid_e = 1'b0;
    step("lduse_after");
    check_eq("lduse_after_outs", 32'(last_out), 32'(OUT_IDLE));

    // Branch with simultaneous load-use flushes instead of stalling.
    valid_e = 1'b1; pc_src_e = 1'b1;
    step("br_lduse");
    check_eq("br_lduse_outs", 32'(last_out), 32'(OUT_FLUSH));
    pc_src_e = 1'b0;

    // x0 destination is never a hazard.
    rd_e = '0; rs1_d = '0;
    step("rd0");
    check_eq("rd0_outs", 32'(last_out), 32'(OUT_IDLE));

    // Miss with refill on the 10th wait cycle: 11 stalled cycles.
    do_reset();
    dcache_miss_m = 1'b1;
    zero_en = 0;
    for (int i = 0; i < 11; i++) begin
      dcache_ready = (i == 10);
      step("miss");
      if (last_out[6:3] == 4'b0000) zero_en++;
    end
    dcache_ready = 1'b0;
    step("miss_resume");
    check_eq("miss_len", 32'(zero_en), 32'd11);
    check_eq("miss_resume_outs", 32'(last_out), 32'(OUT_IDLE));
`ifdef HAZARD_PERF_CNT_EN
    check_eq("miss_cnt", 32'(last_cnt), 32'd11);
`else
    check_eq("miss_cnt", 32'(last_cnt), 32'd0);
`endif
    dcache_miss_m = 1'b0;
    step("miss_done");

    // Reset during a miss wait abandons it.
    dcache_miss_m = 1'b1;
    step("rmiss");
    dcache_miss_m = 1'b0;
    for (int i = 0; i < 3; i++) step("rmiss_wait");
    check_eq("rmiss_wait_outs", 32'(last_out), 32'(OUT_STALL));
    rst_n = 1'b0;
    step("rmiss_rst");
    check_eq("rmiss_rst_outs", 32'(last_out), 32'(OUT_RESET));
    rst_n = 1'b1;
    step("rmiss_rel");
    check_eq("rmiss_rel_outs", 32'(last_out), 32'(OUT_IDLE));
    check_eq("rmiss_rel_cnt", 32'(last_cnt), 32'd0);

    // Long miss drives the counter into saturation.
    dcache_miss_m = 1'b1;
    for (int i = 0; i < 22; i++) step("sat");
`ifdef HAZARD_PERF_CNT_EN
    check_eq("sat_cnt", 32'(last_cnt), 32'(CNT_MAX));
`else
    check_eq("sat_cnt", 32'(last_cnt), 32'd0);
`endif
    dcache_miss_m = 1'b0; dcache_ready = 1'b1;
    step("sat_ready");
    dcache_ready = 1'b0;
    step("sat_resume");

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rst_n         = ($urandom_range(0, 49) != 0);
      rs1_d         = AW'($urandom_range(0, 3));
      rs2_d         = AW'($urandom_range(0, 3));
      rd_e          = AW'($urandom_range(0, 3));
      result_src_e  = SW'($urandom_range(0, 3));
      valid_e       = ($urandom_range(0, 3) != 0);
      pc_src_e      = ($urandom_range(0, 5) == 0);
      dcache_miss_m = ($urandom_range(0, 7) == 0);
      dcache_ready  = ($urandom_range(0, 3) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
